seq_multiplier_hs: RTL and testbench

//  Parametrised sequential shift-add multiplier; successor to the 16x16 combinational array multiplier.

---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/mul_iter_counter.sv | 37 +++
 rtl/seq_multiplier_hs.sv | 132 +++++++++++++
 tb/tb_seq_multiplier_hs.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier and its helpers.
// Holds the FSM state encoding and the iteration-counter width rule.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_iter_counter.sv
// Loadable down-counter for iterative arithmetic units.
// Load has priority over decrement; decrement saturates at zero.
module mul_iter_counter #(
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoadVal,
  input  logic             iDec,
  output logic [CNT_W-1:0] oCount,
  output logic             oZero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iLoad) begin
      cnt_d = iLoadVal;
    end else if (iDec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign oCount = cnt_q;
  assign oZero  = (cnt_q == '0);

endmodule

// File: rtl/seq_multiplier_hs.sv
// Sequential shift-add multiplier, one partial product per cycle, with
// valid/ready handshake on operands and results and optional signed mode.
module seq_multiplier_hs
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oReady,
  output logic               oValid,
  input  logic               iAck,
  output logic [2*WIDTH-1:0] oResult,
  output logic               oBusy
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               accept;
  logic               step;
  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;

  // Magnitude kept unsigned in WIDTH bits so -2^(WIDTH-1) maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  mul_iter_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .Clock    (Clock),
    .Reset    (Reset),
    .iLoad    (cnt_load),
    .iLoadVal (CNT_W'(WIDTH)),
    .iDec     (cnt_dec),
    .oCount   (cnt),
    .oZero    (cnt_zero)
  );

  assign accept = (state_q == ST_IDLE) && iStart;
  assign step   = (state_q == ST_RUN) && !cnt_zero;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_dec = 1'b1;
        // Leave on the edge that performs the last partial product.
        if (cnt == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (iAck) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign addend = p_q[0] ? ma_q : '0;
  assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  always_comb begin
    ma_d     = ma_q;
    p_d      = p_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (accept) begin
      ma_d  = magnitude(iA, iSigned);
      p_d   = {{WIDTH{1'b0}}, magnitude(iB, iSigned)};
      neg_d = iSigned && (iA[WIDTH-1] ^ iB[WIDTH-1]);
    end else if (step) begin
      p_d = {sum, p_q[WIDTH-1:1]};
    end
    if (state_q == ST_FIX) begin
      result_d = neg_q ? -p_q : p_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ma_q     <= '0;
      p_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ma_q     <= ma_d;
      p_q      <= p_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign oReady  = (state_q == ST_IDLE);
  assign oValid  = (state_q == ST_DONE);
  assign oBusy   = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign oResult = result_q;

endmodule

// File: tb/tb_seq_multiplier_hs.sv
// Self-checking bench for seq_multiplier_hs at WIDTH=16: directed corner
// cases followed by random signed/unsigned products against an arithmetic model.
module tb_seq_multiplier_hs;

  localparam int W = 16;
  localparam int LAT_EDGES = W + 1;  // posedges after accept until DONE (the W+2-th cycle)
  localparam int BOUND = 64;

  logic           Clock;
  logic           Reset;
  logic           iStart;
  logic           iSigned;
  logic [W-1:0]   iA;
  logic [W-1:0]   iB;
  logic           oReady;
  logic           oValid;
  logic           iAck;
  logic [2*W-1:0] oResult;
  logic           oBusy;

  int checks = 0;
  int errors = 0;

  seq_multiplier_hs #(.WIDTH(W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iStart  (iStart),
    .iSigned (iSigned),
    .iA      (iA),
    .iB      (iB),
    .oReady  (oReady),
    .oValid  (oValid),
    .iAck    (iAck),
    .oResult (oResult),
    .oBusy   (oBusy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    return (2*W)'(pa * pb);
  endfunction

  // All tasks start and end just after a negedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    iA = a;
    iB = b;
    iSigned = s;
    iStart = 1'b1;
    chk("ready_before_accept", 64'(oReady), 64'(1'b1));
    @(negedge Clock);
    iStart = 1'b0;
    iA = W'($urandom);
    iB = W'($urandom);
    iSigned = ~s;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (oValid !== 1'b1 && edges < BOUND) begin
      @(negedge Clock);
      edges++;
    end
  endtask

  task automatic finish_op(input string tag, input logic [2*W-1:0] exp, input int edges);
    chk({tag, "_latency"}, 64'(edges), 64'(LAT_EDGES));
    chk({tag, "_result"}, 64'(oResult), 64'(exp));
    iAck = 1'b1;
    @(negedge Clock);
    iAck = 1'b0;
    chk({tag, "_ready_after_ack"}, 64'(oReady), 64'(1'b1));
    chk({tag, "_valid_after_ack"}, 64'(oValid), 64'(1'b0));
  endtask

  initial begin
    logic [W-1:0]   a, b;
    logic           s;
    logic [2*W-1:0] exp_r;
    int             lat;

    Reset = 1'b1;
    iStart = 1'b0;
    iSigned = 1'b0;
    iA = '0;
    iB = '0;
    iAck = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    chk("reset_ready", 64'(oReady), 64'(1'b1));
    chk("reset_valid", 64'(oValid), 64'(1'b0));
    chk("reset_busy", 64'(oBusy), 64'(1'b0));
    chk("reset_result", 64'(oResult), 64'h0);

    // Ack with nothing pending is ignored.
    iAck = 1'b1;
    @(negedge Clock);
    iAck = 1'b0;
    chk("idle_ack_ready", 64'(oReady), 64'(1'b1));
    chk("idle_ack_valid", 64'(oValid), 64'(1'b0));

    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    chk("run_busy", 64'(oBusy), 64'(1'b1));
    chk("run_ready", 64'(oReady), 64'(1'b0));
    wait_valid(lat);
    finish_op("umax", 32'hFFFE0001, lat);

    start_op(16'h8000, 16'h8000, 1'b1);
    wait_valid(lat);
    finish_op("smin_sq", 32'h40000000, lat);

    start_op(16'hFFFF, 16'h0003, 1'b1);
    wait_valid(lat);
    finish_op("sneg1x3", 32'hFFFFFFFD, lat);

    start_op(16'h0000, 16'h1234, 1'b0);
    wait_valid(lat);
    finish_op("zero", 32'h0, lat);

    // Start requests and acks while busy must be ignored.
    start_op(16'd1234, 16'd567, 1'b0);
    lat = 0;
    while (oValid !== 1'b1 && lat < BOUND) begin
      chk("busy_ready_low", 64'(oReady), 64'(1'b0));
      chk("busy_flag", 64'(oBusy), 64'(1'b1));
      iStart = 1'b1;
      iA = W'($urandom);
      iB = W'($urandom);
      iSigned = 1'($urandom);
      iAck = 1'($urandom);
      @(negedge Clock);
      lat++;
    end
    iStart = 1'b0;
    iAck = 1'b0;
    exp_r = 32'd699678;
    // Consumer stalls: result must hold.
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      chk("stall_valid", 64'(oValid), 64'(1'b1));
      chk("stall_result", 64'(oResult), 64'(exp_r));
    end
    finish_op("ignored_start", exp_r, lat);
    repeat (3) @(negedge Clock);
    chk("idle_hold_result", 64'(oResult), 64'(exp_r));

    // Reset in the middle of RUN aborts the operation.
    start_op(16'h1357, 16'h2468, 1'b0);
    repeat (4) @(negedge Clock);
    chk("pre_reset_busy", 64'(oBusy), 64'(1'b1));
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort_ready", 64'(oReady), 64'(1'b1));
    chk("abort_valid", 64'(oValid), 64'(1'b0));
    chk("abort_busy", 64'(oBusy), 64'(1'b0));
    chk("abort_result", 64'(oResult), 64'h0);
    start_op(16'd7, 16'd9, 1'b0);
    wait_valid(lat);
    finish_op("after_abort", 32'd63, lat);

    for (int i = 0; i < 1500; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom_range(0, 1));
      case (i % 16)
        0: a = 16'h8000;
        1: b = 16'h8000;
        2: a = 16'hFFFF;
        3: b = 16'h0000;
        4: begin a = 16'h7FFF; b = 16'h8000; end
        default: ;
      endcase
      exp_r = ref_mul(a, b, s);
      start_op(a, b, s);
      wait_valid(lat);
      finish_op("random", exp_r, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
